// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes, ALUOp, funct and ALU control codes.
package mips_mc_pkg;

    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control <-> datapath signal bundle; master is the control unit, slave is the datapath.
interface mips_mc_control_if #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
);
    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               iord;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_control;
    logic [1:0]         pc_src;
    logic               pc_en;
    logic [3:0]         state_dbg;

    modport master (
        input  opcode, funct, zero,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, state_dbg
    );

    modport slave (
        output opcode, funct, zero,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, state_dbg
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder: ALUOp plus funct field -> 3-bit ALU operation.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  aluop_t             alu_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [2:0]         alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    F_SUB:   alu_control_o = ALU_SUB;
                    F_AND:   alu_control_o = ALU_AND;
                    F_OR:    alu_control_o = ALU_OR;
                    F_SLT:   alu_control_o = ALU_SLT;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: Moore FSM driving datapath register enables and mux selects.
// Optional MIPS_MC_BNE_EN adds bne (opcode 000101) through the shared BRANCH state.
module mips_mc_control
    import mips_mc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mips_mc_control_if.master bus
);

    state_t     state_q, state_d;
    aluop_t     alu_op;
    logic [2:0] alu_ctl;
    logic       pc_write, branch, taken, illegal;
    logic       iord_c, mem_write_c, ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = S_FETCH;
        alu_op       = ALUOP_ADD;
        pc_write     = 1'b0;
        branch       = 1'b0;
        taken        = 1'b0;
        illegal      = 1'b0;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        pc_src_c     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_c  = 1'b1;
                alu_src_b_c = 2'b01;
                pc_write    = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_c  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
            end
            S_MEMWR: begin
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op      = ALUOP_SUB;
                pc_src_c    = 2'b01;
                branch      = 1'b1;
`ifdef MIPS_MC_BNE_EN
                taken       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
                taken       = bus.zero;
`endif
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: reg_write_c = 1'b1;
            S_JUMP: begin
                pc_src_c = 2'b10;
                pc_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct_i       (bus.funct),
        .alu_control_o (alu_ctl)
    );

    // Reset blanks every output so no write strobe can fire during a mid-instruction reset.
    assign bus.iord        = ~reset & iord_c;
    assign bus.mem_write   = ~reset & mem_write_c;
    assign bus.ir_write    = ~reset & ir_write_c;
    assign bus.reg_dst     = ~reset & reg_dst_c;
    assign bus.mem_to_reg  = ~reset & mem_to_reg_c;
    assign bus.reg_write   = ~reset & reg_write_c;
    assign bus.alu_src_a   = ~reset & alu_src_a_c;
    assign bus.alu_src_b   = reset ? 2'b00 : alu_src_b_c;
    assign bus.pc_src      = reset ? 2'b00 : pc_src_c;
    assign bus.alu_control = (reset || illegal) ? 3'b000 : alu_ctl;
    assign bus.pc_en       = ~reset & (pc_write | (branch & taken));
    assign bus.state_dbg   = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed-vector bench for mips_mc_control; expectations hand-derived from the state table.
module tb_mips_mc_control;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    mips_mc_control_if bus ();

    mips_mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic z);
        reset      = rst;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        #1;
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
    logic [2:0] ctl_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};

    initial begin
        set_in(1'b1, 6'b000000, 6'b000000, 1'b0);
        cyc();
        cyc();
        chk("rst_state", 8'(bus.state_dbg), 8'd0);
        chk("rst_irw", 8'(bus.ir_write), 8'd0);
        chk("rst_pcen", 8'(bus.pc_en), 8'd0);

        // lw: 0,1,2,3,4,0
        set_in(1'b0, 6'b100011, 6'b000000, 1'b0);
        chk("lw_f_state", 8'(bus.state_dbg), 8'd0);
        chk("lw_f_irw", 8'(bus.ir_write), 8'd1);
        chk("lw_f_pcen", 8'(bus.pc_en), 8'd1);
        chk("lw_f_srcb", 8'(bus.alu_src_b), 8'd1);
        chk("lw_f_alu", 8'(bus.alu_control), 8'b010);
        cyc();
        chk("lw_d_state", 8'(bus.state_dbg), 8'd1);
        chk("lw_d_srcb", 8'(bus.alu_src_b), 8'd3);
        chk("lw_d_regw", 8'(bus.reg_write), 8'd0);
        cyc();
        chk("lw_a_state", 8'(bus.state_dbg), 8'd2);
        chk("lw_a_srca", 8'(bus.alu_src_a), 8'd1);
        chk("lw_a_srcb", 8'(bus.alu_src_b), 8'd2);
        cyc();
        chk("lw_r_state", 8'(bus.state_dbg), 8'd3);
        chk("lw_r_iord", 8'(bus.iord), 8'd1);
        chk("lw_r_regw", 8'(bus.reg_write), 8'd0);
        cyc();
        chk("lw_wb_state", 8'(bus.state_dbg), 8'd4);
        chk("lw_wb_regw", 8'(bus.reg_write), 8'd1);
        chk("lw_wb_m2r", 8'(bus.mem_to_reg), 8'd1);
        chk("lw_wb_rdst", 8'(bus.reg_dst), 8'd0);
        cyc();
        chk("lw_end_state", 8'(bus.state_dbg), 8'd0);

        // reset held two cycles from MEMRD
        cyc();
        cyc();
        cyc();
        chk("mid_state", 8'(bus.state_dbg), 8'd3);
        set_in(1'b1, 6'b100011, 6'b000000, 1'b0);
        chk("mid_iord", 8'(bus.iord), 8'd0);
        chk("mid_regw", 8'(bus.reg_write), 8'd0);
        chk("mid_memw", 8'(bus.mem_write), 8'd0);
        cyc();
        chk("mid_regw2", 8'(bus.reg_write), 8'd0);
        chk("mid_pcen2", 8'(bus.pc_en), 8'd0);
        cyc();
        set_in(1'b0, 6'b101011, 6'b000000, 1'b0);
        chk("rel_state", 8'(bus.state_dbg), 8'd0);
        chk("rel_irw", 8'(bus.ir_write), 8'd1);
        chk("rel_pcen", 8'(bus.pc_en), 8'd1);

        // sw: 0,1,2,5,0
        cyc();
        cyc();
        cyc();
        chk("sw_state", 8'(bus.state_dbg), 8'd5);
        chk("sw_memw", 8'(bus.mem_write), 8'd1);
        chk("sw_iord", 8'(bus.iord), 8'd1);
        cyc();
        chk("sw_end", 8'(bus.state_dbg), 8'd0);

        // R-type slt: 0,1,6,7,0
        set_in(1'b0, 6'b000000, 6'b101010, 1'b0);
        cyc();
        cyc();
        chk("slt_state", 8'(bus.state_dbg), 8'd6);
        chk("slt_alu", 8'(bus.alu_control), 8'b111);
        chk("slt_srca", 8'(bus.alu_src_a), 8'd1);
        chk("slt_srcb", 8'(bus.alu_src_b), 8'd0);
        cyc();
        chk("slt_wb_state", 8'(bus.state_dbg), 8'd7);
        chk("slt_wb_rdst", 8'(bus.reg_dst), 8'd1);
        chk("slt_wb_regw", 8'(bus.reg_write), 8'd1);
        chk("slt_wb_m2r", 8'(bus.mem_to_reg), 8'd0);
        cyc();
        chk("slt_end", 8'(bus.state_dbg), 8'd0);

        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 6'b000000, fn_tab[i], 1'b0);
            cyc();
            cyc();
            chk($sformatf("rt_alu_%0d", i), 8'(bus.alu_control), 8'(ctl_tab[i]));
            cyc();
            cyc();
        end

        // addi: 0,1,9,10,0
        set_in(1'b0, 6'b001000, 6'b000000, 1'b0);
        cyc();
        cyc();
        chk("addi_ex_state", 8'(bus.state_dbg), 8'd9);
        chk("addi_ex_srcb", 8'(bus.alu_src_b), 8'd2);
        chk("addi_ex_alu", 8'(bus.alu_control), 8'b010);
        cyc();
        chk("addi_wb_state", 8'(bus.state_dbg), 8'd10);
        chk("addi_wb_regw", 8'(bus.reg_write), 8'd1);
        chk("addi_wb_rdst", 8'(bus.reg_dst), 8'd0);
        cyc();

        // beq taken then not taken
        set_in(1'b0, 6'b000100, 6'b000000, 1'b1);
        cyc();
        cyc();
        chk("beq1_state", 8'(bus.state_dbg), 8'd8);
        chk("beq1_pcen", 8'(bus.pc_en), 8'd1);
        chk("beq1_pcsrc", 8'(bus.pc_src), 8'd1);
        chk("beq1_alu", 8'(bus.alu_control), 8'b110);
        cyc();
        chk("beq1_end", 8'(bus.state_dbg), 8'd0);
        set_in(1'b0, 6'b000100, 6'b000000, 1'b0);
        cyc();
        cyc();
        chk("beq0_state", 8'(bus.state_dbg), 8'd8);
        chk("beq0_pcen", 8'(bus.pc_en), 8'd0);
        chk("beq0_alu", 8'(bus.alu_control), 8'b110);
        cyc();

        // j: 0,1,11,0
        set_in(1'b0, 6'b000010, 6'b000000, 1'b0);
        cyc();
        cyc();
        chk("j_state", 8'(bus.state_dbg), 8'd11);
        chk("j_pcsrc", 8'(bus.pc_src), 8'd2);
        chk("j_pcen", 8'(bus.pc_en), 8'd1);
        cyc();
        chk("j_end", 8'(bus.state_dbg), 8'd0);

        // illegal opcode: 0,1,0
        set_in(1'b0, 6'b111111, 6'b000000, 1'b0);
        cyc();
        chk("ill_d_state", 8'(bus.state_dbg), 8'd1);
        chk("ill_d_regw", 8'(bus.reg_write), 8'd0);
        chk("ill_d_memw", 8'(bus.mem_write), 8'd0);
        chk("ill_d_pcen", 8'(bus.pc_en), 8'd0);
        cyc();
        chk("ill_end", 8'(bus.state_dbg), 8'd0);

        // bne with zero=0
        set_in(1'b0, 6'b000101, 6'b000000, 1'b0);
        cyc();
        cyc();
`ifdef MIPS_MC_BNE_EN
        chk("bne_state", 8'(bus.state_dbg), 8'd8);
        chk("bne_pcen", 8'(bus.pc_en), 8'd1);
        chk("bne_alu", 8'(bus.alu_control), 8'b110);
        cyc();
`else
        chk("bne_state", 8'(bus.state_dbg), 8'd0);
        chk("bne_irw", 8'(bus.ir_write), 8'd1);
`endif
        chk("bne_end", 8'(bus.state_dbg), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
